// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee order scheduler: machine state codes,
// scheduler states and default start timeout.
package coffee_pkg;

    localparam logic [3:0] M_IDLE      = 4'd1;
    localparam logic [3:0] M_SELECT    = 4'd2;
    localparam logic [3:0] M_PAY       = 4'd3;
    localparam logic [3:0] M_GRIND     = 4'd4;
    localparam logic [3:0] M_HEAT      = 4'd5;
    localparam logic [3:0] M_TAMP      = 4'd6;
    localparam logic [3:0] M_PREINFUSE = 4'd7;
    localparam logic [3:0] M_PRESS     = 4'd8;
    localparam logic [3:0] M_EXTRACAO  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BREW,
        S_DONE
    } sched_state_t;

    localparam int unsigned START_TIMEOUT_DEF = 16;

    function automatic logic mach_code_valid(input logic [3:0] code);
        case (code)
            M_IDLE, M_SELECT, M_PAY, M_GRIND, M_HEAT,
            M_TAMP, M_PREINFUSE, M_PRESS, M_EXTRACAO: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/coffee_order_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// wrapping modulo N_REQ; one-hot grant plus valid.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned PW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic             valid
);

    localparam logic [PW:0] N_W = (PW + 1)'(N_REQ);

    logic [PW:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (PW + 1)'(i);
            if (idx >= N_W) begin
                idx = idx - N_W;
            end
            if (!valid && req[idx[PW-1:0]]) begin
                gnt[idx[PW-1:0]] = 1'b1;
                valid            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coffee_order_scheduler.sv
// Shares one coffee machine among N_REQ requesters, round-robin.
// Define COFFEE_SCHED_STATS_EN to add the served_cnt / abort_cnt outputs.
module coffee_order_scheduler
    import coffee_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [3:0]       mach_state,
    output logic             mach_start,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic             timeout_err
`ifdef COFFEE_SCHED_STATS_EN
    ,
    output logic [15:0]      served_cnt,
    output logic [7:0]       abort_cnt
`endif
);

    localparam int unsigned PW = $clog2(N_REQ);
    localparam int unsigned TW = $clog2(START_TIMEOUT + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

    sched_state_t     state;
    logic [N_REQ-1:0] pending;
    logic [PW-1:0]    rr_ptr;
    logic             saw_extract;
    logic [TW-1:0]    tmo_cnt;

    logic [N_REQ-1:0] req_all;
    logic [N_REQ-1:0] arb_gnt;
    logic             arb_valid;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    next_ptr;
    logic [N_REQ-1:0] pend_release;

    // Same-cycle requests take part in arbitration so an idle scheduler grants one cycle after req.
    assign req_all = pending | req;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req_all),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_idx = PW'(i);
            end
        end
        next_ptr     = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        pend_release = (pending & ~grant) | req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pending     <= '0;
            rr_ptr      <= '0;
            saw_extract <= 1'b0;
            tmo_cnt     <= '0;
            mach_start  <= 1'b0;
            grant       <= '0;
            done        <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
`ifdef COFFEE_SCHED_STATS_EN
            served_cnt  <= '0;
            abort_cnt   <= '0;
`endif
        end else begin
            done        <= '0;
            timeout_err <= 1'b0;
            pending     <= req_all;
            unique case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        grant <= arb_gnt;
                        busy  <= 1'b1;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (mach_state != M_IDLE) begin
                        state      <= S_BREW;
                        mach_start <= 1'b0;
                        tmo_cnt    <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state       <= S_IDLE;
                        mach_start  <= 1'b0;
                        tmo_cnt     <= '0;
                        timeout_err <= 1'b1;
                        pending     <= pend_release;
                        rr_ptr      <= next_ptr;
                        grant       <= '0;
                        busy        <= 1'b0;
`ifdef COFFEE_SCHED_STATS_EN
                        abort_cnt   <= (abort_cnt == 8'hFF) ? abort_cnt : abort_cnt + 8'd1;
`endif
                    end else begin
                        mach_start <= 1'b1;
                        tmo_cnt    <= tmo_cnt + 1'b1;
                    end
                end
                S_BREW: begin
                    if (mach_state == M_EXTRACAO) begin
                        saw_extract <= 1'b1;
                    end
                    if (saw_extract && mach_state == M_IDLE) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done        <= grant;
                    pending     <= pend_release;
                    saw_extract <= 1'b0;
                    rr_ptr      <= next_ptr;
                    grant       <= '0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
`ifdef COFFEE_SCHED_STATS_EN
                    served_cnt  <= served_cnt + 16'd1;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coffee_order_scheduler.sv
// Self-checking bench for coffee_order_scheduler: machine model, order-level
// reference model, vector table, corner-case sequences and random traffic.
module tb_coffee_order_scheduler;

    localparam int unsigned NR  = 4;
    localparam int unsigned TMO = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req   = '0;
    logic [3:0]    mach_state;
    logic          mach_start;
    logic [NR-1:0] grant;
    logic [NR-1:0] done;
    logic          busy;
    logic          timeout_err;
`ifdef COFFEE_SCHED_STATS_EN
    logic [15:0]   served_cnt;
    logic [7:0]    abort_cnt;
`endif

    always #5 clk = ~clk;

    coffee_order_scheduler #(.N_REQ(NR), .START_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .mach_state  (mach_state),
        .mach_start  (mach_start),
        .grant       (grant),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err)
`ifdef COFFEE_SCHED_STATS_EN
        ,
        .served_cnt  (served_cnt),
        .abort_cnt   (abort_cnt)
`endif
    );

    // Coffee machine: leaves IDLE on start, walks codes 2..9 (dwell cycles each), back to 1.
    logic [3:0]  m_state = 4'd1;
    int unsigned m_cnt   = 0;
    int unsigned dwell   = 1;
    logic        stuck   = 1'b0;
    logic        glitch  = 1'b0;

    always @(posedge clk) begin
        if (m_state == 4'd1) begin
            if (mach_start && !stuck) begin
                m_state <= 4'd2;
                m_cnt   <= 0;
            end
        end else if (m_cnt + 1 < dwell) begin
            m_cnt <= m_cnt + 1;
        end else begin
            m_cnt   <= 0;
            m_state <= (m_state == 4'd9) ? 4'd1 : m_state + 4'd1;
        end
    end

    assign mach_state = glitch ? 4'd12 : m_state;

    // Reference model: one order in service at a time, tracked by owner index and lifecycle flags.
    int          owner = -1;
    int          age   = 0;
    int          mptr  = 0;
    bit          left_idle, seen_ext, finishing;
    logic [3:0]  mpend = '0;
    logic [3:0]  e_grant = '0, e_done = '0;
    logic        e_busy = 1'b0, e_start = 1'b0, e_tmo = 1'b0;

    task automatic mreset();
        owner = -1; age = 0; mptr = 0; mpend = '0;
        left_idle = 0; seen_ext = 0; finishing = 0;
        e_grant = '0; e_done = '0; e_busy = 0; e_start = 0; e_tmo = 0;
    endtask

    task automatic release_owner(input logic [3:0] r);
        mpend = (mpend & ~4'(1 << owner)) | r;
        mptr  = (owner + 1) % NR;
        owner = -1;
    endtask

    task automatic mstep(input logic [3:0] r, input logic [3:0] ms);
        e_done = '0; e_tmo = 0; e_start = 0;
        if (owner < 0) begin
            mpend = mpend | r;
            for (int k = 0; k < NR; k++) begin
                if (owner < 0 && mpend[(mptr + k) % NR]) owner = (mptr + k) % NR;
            end
            age = 0; left_idle = 0; seen_ext = 0; finishing = 0;
        end else if (finishing) begin
            e_done = 4'(1 << owner);
            release_owner(r);
        end else if (!left_idle) begin
            if (ms != 4'd1) begin
                left_idle = 1;
                mpend = mpend | r;
            end else if (age == TMO - 1) begin
                e_tmo = 1;
                release_owner(r);
            end else begin
                age++;
                e_start = 1;
                mpend = mpend | r;
            end
        end else begin
            if (seen_ext && ms == 4'd1) finishing = 1;
            if (ms == 4'd9) seen_ext = 1;
            mpend = mpend | r;
        end
        e_grant = (owner >= 0) ? 4'(1 << owner) : '0;
        e_busy  = (owner >= 0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mreset();
        else        mstep(req, mach_state);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // One clock: compare against the model on the falling edge, return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            n_tests++;
            if ({grant, done, busy, mach_start, timeout_err} !== {e_grant, e_done, e_busy, e_start, e_tmo}) begin
                n_fail++;
                $display("FAIL model t=%0t grant=%b/%b done=%b/%b busy=%b/%b start=%b/%b tmo=%b/%b",
                         $time, grant, e_grant, done, e_done, busy, e_busy, mach_start, e_start,
                         timeout_err, e_tmo);
            end
        end
        @(posedge clk);
        #1;
    endtask

    int unsigned dcnt [NR];

    task automatic drain(input int max_cyc);
        int idle_run;
        int cyc;
        idle_run = 0;
        cyc = 0;
        for (int i = 0; i < NR; i++) dcnt[i] = 0;
        while (idle_run < 2 && cyc < max_cyc) begin
            for (int i = 0; i < NR; i++) if (done[i]) dcnt[i]++;
            idle_run = busy ? 0 : idle_run + 1;
            tick();
            cyc++;
        end
        if (idle_run < 2) bound_fail("drain");
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  exp_grant;
        int unsigned exp_lat;
    } vec_t;

    vec_t vt [7];
    int   got [$];

    initial begin
        int unsigned lat;
        int cyc;
        int phase;
        bit sent;
        int exp_a [5];
        int exp_c [4];

        vt[0] = '{4'b0100, 4'b0100, 13};
        vt[1] = '{4'b0011, 4'b0001, 13};
        vt[2] = '{4'b1000, 4'b1000, 13};
        vt[3] = '{4'b1111, 4'b0001, 13};
        vt[4] = '{4'b0010, 4'b0010, 13};
        vt[5] = '{4'b0101, 4'b0100, 13};
        vt[6] = '{4'b1000, 4'b1000, 13};
        exp_a = '{0, 1, 2, 3, 0};
        exp_c = '{2, 0, 1, 0};

        repeat (3) tick();
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", mach_start, 0);
        chk("rst_tmo", timeout_err, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            req = vt[i].req;
            tick();
            req = '0;
            chk("vec_grant", grant, vt[i].exp_grant);
            tick();
            chk("vec_start", mach_start, 1);
            lat = 2;
            while (done == '0 && lat < 100) begin
                tick();
                lat++;
            end
            chk("vec_done", done, vt[i].exp_grant);
            chk("vec_latency", lat, vt[i].exp_lat);
`ifdef COFFEE_SCHED_STATS_EN
            if (i == 0) chk("served_cnt", served_cnt, 1);
`endif
            drain(400);
        end

        // Fairness: all four at once, plus port 0 re-requesting while port 1 brews.
        req = 4'b1111;
        tick();
        req = '0;
        got.delete();
        sent = 0;
        cyc = 0;
        while (got.size() < 5 && cyc < 400) begin
            if (done != '0) got.push_back(idx_of(done));
            if (!sent && grant == 4'b0010 && m_state == 4'd5) begin
                req = 4'b0001;
                sent = 1;
            end
            tick();
            req = '0;
            cyc++;
        end
        for (int i = 0; i < 5; i++) chk("rr_order", (i < got.size()) ? got[i] : -1, exp_a[i]);
        drain(400);

        // Duplicate requests on port 1 while port 3 is being served.
        req = 4'b1000;
        tick();
        req = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
            req = 4'b0010;
            tick();
            req = '0;
        end
        drain(400);
        chk("dup_done1", dcnt[1], 1);
        chk("dup_done3", dcnt[3], 1);

        // Port 0 re-requests in its own completion cycle.
        req = 4'b0111;
        tick();
        req = '0;
        got.delete();
        phase = 0;
        cyc = 0;
        while (got.size() < 4 && cyc < 500) begin
            if (done != '0) got.push_back(idx_of(done));
            if (phase == 2) begin
                req = 4'b0001;
                phase = 3;
            end else if (phase == 1 && m_state == 4'd1) begin
                phase = 2;
            end else if (phase == 0 && grant == 4'b0001 && m_state == 4'd9) begin
                phase = 1;
            end
            tick();
            req = '0;
            cyc++;
        end
        for (int i = 0; i < 4; i++) chk("clrset_order", (i < got.size()) ? got[i] : -1, exp_c[i]);
        drain(400);

        // Start timeout with the machine ignoring start.
        stuck = 1'b1;
        req = 4'b0010;
        tick();
        req = '0;
        chk("tmo_grant", grant, 4'b0010);
        lat = 1;
        while (!timeout_err && lat < 60) begin
            tick();
            lat++;
        end
        chk("tmo_latency", lat, 17);
        chk("tmo_busy", busy, 0);
        chk("tmo_grant_clr", grant, 0);
`ifdef COFFEE_SCHED_STATS_EN
        chk("abort_cnt", abort_cnt, 1);
`endif
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("tmo_stays_idle", busy, 0);
        end
        stuck = 1'b0;
        tick();

        // Reset in the middle of a brew.
        req = 4'b0001;
        tick();
        req = '0;
        cyc = 0;
        while (m_state != 4'd5 && cyc < 50) begin
            tick();
            cyc++;
        end
        if (m_state != 4'd5) bound_fail("reach_state5");
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", grant, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_start", mach_start, 0);
        tick();
        tick();
        rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            if (done != '0) lat++;
            tick();
        end
        chk("midrst_no_done", lat, 0);
        chk("midrst_idle", busy, 0);
`ifdef COFFEE_SCHED_STATS_EN
        chk("midrst_served", served_cnt, 0);
`endif

        // Random traffic checked cycle by cycle against the model.
        for (int c = 0; c < 1500; c++) begin
            req = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : '0;
            glitch = (m_state >= 4'd2 && m_state <= 4'd8 && $urandom_range(0, 9) == 0);
            if (m_state == 4'd1) dwell = $urandom_range(1, 3);
            tick();
        end
        req = '0;
        glitch = 1'b0;
        drain(600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
